// File: rtl/btb_update_arb_pkg.sv
// Shared ISA word type and BTB update arbiter datapath types.
package isa_pkg;
    typedef logic [31:0] word_t;
endpackage

package btb_update_arb_pkg;
    import isa_pkg::*;

    typedef struct packed {
        word_t pc;
        word_t target;
        logic  taken;
    } btb_update_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        HELD
    } btb_arb_state_t;
endpackage

// File: rtl/btb_update_arb_if.sv
// Requester and BTB update bundle for the BTB update arbiter.
interface btb_update_arb_if #(
    parameter int NREQ = 2
);
    import isa_pkg::*;

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0][31:0]  req_pc;
    logic [NREQ-1:0][31:0]  req_target;
    logic [NREQ-1:0]        req_taken;

    logic                   update_btb;
    word_t                  pc;
    word_t                  branch_target;
    logic                   branch_outcome;

    modport master (
        output req_valid, req_pc, req_target, req_taken,
        input  req_ready, update_btb, pc, branch_target, branch_outcome
    );

    modport slave (
        input  req_valid, req_pc, req_target, req_taken,
        output req_ready, update_btb, pc, branch_target, branch_outcome
    );
endinterface

// File: rtl/btb_update_arb_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after the pointer wins.
module rr_arbiter #(
    parameter  int N = 2,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    input  logic         en_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] idx_o
);
    always_comb begin
        logic       found;
        logic [W:0] j;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = {1'b0, ptr_i} + (W+1)'(k);
            if (j >= (W+1)'(N)) begin
                j = j - (W+1)'(N);
            end
            if (en_i && !found && req_i[j[W-1:0]]) begin
                found = 1'b1;
                idx_o = j[W-1:0];
                gnt_o[j[W-1:0]] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/btb_update_arb.sv
// Shares the BTB update port among branch units via an RR-fed coalescing queue.
module btb_update_arb
    import btb_update_arb_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int DEPTH = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic hold,
    input  logic flush,
    output logic busy,
    btb_update_arb_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;

    btb_update_t    mem_q [DEPTH];
    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;
    logic [RW-1:0]  rr_q, rr_d;
    btb_arb_state_t state_q, state_d;
    btb_update_t    out_q, out_d;
    logic           upd_q, upd_d;

    logic [NREQ-1:0] gnt;
    logic [RW-1:0]   gidx;
    logic            arb_en;
    logic            accept;
    logic            coalesce;
    logic            bypass;
    logic            push;
    logic            pop;
    logic [PW-1:0]   tail_last;
    btb_update_t     req_ent;

    assign arb_en = !RST && !flush && (count_q != CW'(DEPTH));

    rr_arbiter #(.N(NREQ)) u_rr (
        .req_i (bus.req_valid),
        .ptr_i (rr_q),
        .en_i  (arb_en),
        .gnt_o (gnt),
        .idx_o (gidx)
    );

    assign bus.req_ready = gnt;
    assign accept        = |gnt;
    assign req_ent.pc     = bus.req_pc[gidx];
    assign req_ent.target = bus.req_target[gidx];
    assign req_ent.taken  = bus.req_taken[gidx];

    // With >=2 entries the tail can never be the entry being popped.
    assign tail_last = tail_q - PW'(1);
    assign coalesce  = accept && (count_q >= CW'(2))
                     && (mem_q[tail_last].pc == req_ent.pc);
    assign pop       = (count_q != '0) && !hold && !flush;
    assign bypass    = accept && (count_q == '0) && !hold;
    assign push      = accept && !coalesce && !bypass;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        rr_d    = rr_q;
        out_d   = out_q;
        upd_d   = 1'b0;
        if (flush) begin
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            if (accept) begin
                rr_d = (gidx == RW'(NREQ - 1)) ? '0 : gidx + RW'(1);
            end
            if (push) begin
                tail_d = tail_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
                out_d  = mem_q[head_q];
                upd_d  = 1'b1;
            end else if (bypass) begin
                out_d = req_ent;
                upd_d = 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[tail_q] <= req_ent;
        end else if (coalesce) begin
            mem_q[tail_last].target <= req_ent.target;
            mem_q[tail_last].taken  <= req_ent.taken;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) state_d = DRAIN;
                end
                DRAIN: begin
                    if (hold) state_d = HELD;
                    else if (count_d == '0 && !accept) state_d = IDLE;
                end
                HELD: begin
                    if (!hold) state_d = (count_q != '0) ? DRAIN : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            rr_q    <= '0;
            out_q   <= '0;
            upd_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            rr_q    <= rr_d;
            out_q   <= out_d;
            upd_q   <= upd_d;
        end
    end

    assign bus.update_btb     = upd_q;
    assign bus.pc             = out_q.pc;
    assign bus.branch_target  = out_q.target;
    assign bus.branch_outcome = out_q.taken;
    assign busy               = (state_q != IDLE) || upd_q;
endmodule

// File: tb/tb_btb_update_arb.sv
// Directed vector table plus randomized run against a queue-level model.
module tb_btb_update_arb;
    localparam int NREQ  = 2;
    localparam int DEPTH = 4;

    logic CLK;
    logic RST;
    logic hold;
    logic flush;
    logic busy;

    btb_update_arb_if #(.NREQ(NREQ)) bus ();

    btb_update_arb #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .hold  (hold),
        .flush (flush),
        .busy  (busy),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst, fl, hd;
        logic [1:0]  v;
        logic [31:0] p0, t0;
        logic        k0;
        logic [31:0] p1, t1;
        logic        k1;
        logic [1:0]  rdy;
        logic        upd;
        logic [31:0] opc, otg;
        logic        otk, bsy;
    } vec_t;

    typedef struct {
        logic [31:0] pc, tgt;
        logic        tk;
    } ent_t;

    int n_chk = 0;
    int n_fail = 0;

    function automatic vec_t mk(
        input logic r, f, h, input logic [1:0] v,
        input logic [31:0] p0, t0, input logic k0,
        input logic [31:0] p1, t1, input logic k1,
        input logic [1:0] rd, input logic u,
        input logic [31:0] op, ot, input logic ok, input logic b);
        vec_t x;
        x.rst = r; x.fl = f; x.hd = h; x.v = v;
        x.p0 = p0; x.t0 = t0; x.k0 = k0;
        x.p1 = p1; x.t1 = t1; x.k1 = k1;
        x.rdy = rd; x.upd = u; x.opc = op; x.otg = ot;
        x.otk = ok; x.bsy = b;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, f, h, input logic [1:0] v,
                         input logic [31:0] p0, t0, input logic k0,
                         input logic [31:0] p1, t1, input logic k1);
        RST = r; flush = f; hold = h;
        bus.req_valid     = v;
        bus.req_pc[0]     = p0; bus.req_target[0] = t0;
        bus.req_taken[0]  = k0;
        bus.req_pc[1]     = p1; bus.req_target[1] = t1;
        bus.req_taken[1]  = k1;
    endtask

    task automatic chk_out(input string tag, input logic u,
                           input logic [31:0] op, ot,
                           input logic ok, b);
        chk({tag, " update_btb"}, {31'b0, bus.update_btb}, {31'b0, u});
        chk({tag, " pc"}, bus.pc, op);
        chk({tag, " branch_target"}, bus.branch_target, ot);
        chk({tag, " branch_outcome"}, {31'b0, bus.branch_outcome}, {31'b0, ok});
        chk({tag, " busy"}, {31'b0, busy}, {31'b0, b});
    endtask

    vec_t tv[$];
    ent_t mq[$];
    ent_t mout, e;
    logic mupd;
    int   mptr, mst, g, pre, i;
    logic [1:0] exp_rdy;
    logic [31:0] pcl[3];
    logic r_rst, r_fl, r_hd, k0, k1;
    logic [1:0] rv;
    logic [31:0] p0, p1, t0, t1;

    initial begin
        // rst fl hd v   p0 t0 k0  p1 t1 k1 | rdy upd pc tgt tk busy
        tv.push_back(mk(1,0,0,2'b11, 0,0,0, 0,0,0, 2'b00, 0,0,0,0,0));
        tv.push_back(mk(0,0,0,2'b01, 'h100,'h200,1, 0,0,0, 2'b01, 1,'h100,'h200,1,1));
        tv.push_back(mk(0,0,0,2'b00, 0,0,0, 0,0,0, 2'b00, 0,'h100,'h200,1,0));
        tv.push_back(mk(1,0,0,2'b00, 0,0,0, 0,0,0, 2'b00, 0,0,0,0,0));
        tv.push_back(mk(0,0,0,2'b11, 'h10,'h1010,0, 'h20,'h1020,1, 2'b01, 1,'h10,'h1010,0,1));
        tv.push_back(mk(0,0,0,2'b11, 'h10,'h1010,0, 'h20,'h1020,1, 2'b10, 1,'h20,'h1020,1,1));
        tv.push_back(mk(0,0,0,2'b11, 'h10,'h1010,0, 'h20,'h1020,1, 2'b01, 1,'h10,'h1010,0,1));
        tv.push_back(mk(0,0,0,2'b11, 'h10,'h1010,0, 'h20,'h1020,1, 2'b10, 1,'h20,'h1020,1,1));
        tv.push_back(mk(0,0,0,2'b00, 0,0,0, 0,0,0, 2'b00, 0,'h20,'h1020,1,0));
        tv.push_back(mk(0,0,1,2'b01, 'h40,'h140,0, 0,0,0, 2'b01, 0,'h20,'h1020,1,1));
        tv.push_back(mk(0,0,1,2'b10, 0,0,0, 'h80,'h180,0, 2'b10, 0,'h20,'h1020,1,1));
        tv.push_back(mk(0,0,1,2'b01, 'h80,'h300,1, 0,0,0, 2'b01, 0,'h20,'h1020,1,1));
        tv.push_back(mk(0,0,0,2'b00, 0,0,0, 0,0,0, 2'b00, 1,'h40,'h140,0,1));
        tv.push_back(mk(0,0,0,2'b00, 0,0,0, 0,0,0, 2'b00, 1,'h80,'h300,1,1));
        tv.push_back(mk(0,0,0,2'b00, 0,0,0, 0,0,0, 2'b00, 0,'h80,'h300,1,0));
        tv.push_back(mk(0,0,1,2'b11, 'hA0,'h10A0,1, 'hB0,'h10B0,0, 2'b10, 0,'h80,'h300,1,1));
        tv.push_back(mk(0,0,1,2'b11, 'hC0,'h10C0,1, 'hD0,'h10D0,0, 2'b01, 0,'h80,'h300,1,1));
        tv.push_back(mk(0,0,1,2'b11, 'hE0,'h10E0,1, 'hF0,'h10F0,0, 2'b10, 0,'h80,'h300,1,1));
        tv.push_back(mk(0,0,1,2'b11, 'h110,'h1110,1, 'h120,'h1120,0, 2'b01, 0,'h80,'h300,1,1));
        tv.push_back(mk(0,0,1,2'b11, 'h110,'h1110,1, 'h120,'h1120,0, 2'b00, 0,'h80,'h300,1,1));
        tv.push_back(mk(0,0,0,2'b11, 'h110,'h1110,1, 'h120,'h1120,0, 2'b00, 1,'hB0,'h10B0,0,1));
        tv.push_back(mk(0,0,0,2'b11, 'h130,'h1130,1, 'h140,'h1140,0, 2'b10, 1,'hC0,'h10C0,1,1));
        tv.push_back(mk(0,0,0,2'b00, 0,0,0, 0,0,0, 2'b00, 1,'hF0,'h10F0,0,1));
        tv.push_back(mk(0,0,0,2'b00, 0,0,0, 0,0,0, 2'b00, 1,'h110,'h1110,1,1));
        tv.push_back(mk(0,0,0,2'b00, 0,0,0, 0,0,0, 2'b00, 1,'h140,'h1140,0,1));
        tv.push_back(mk(0,0,0,2'b00, 0,0,0, 0,0,0, 2'b00, 0,'h140,'h1140,0,0));
        tv.push_back(mk(0,0,1,2'b01, 'h200,'h1200,1, 0,0,0, 2'b01, 0,'h140,'h1140,0,1));
        tv.push_back(mk(0,0,1,2'b10, 0,0,0, 'h210,'h1210,0, 2'b10, 0,'h140,'h1140,0,1));
        tv.push_back(mk(0,0,1,2'b01, 'h220,'h1220,1, 0,0,0, 2'b01, 0,'h140,'h1140,0,1));
        tv.push_back(mk(0,0,0,2'b10, 0,0,0, 'h230,'h1230,0, 2'b10, 1,'h200,'h1200,1,1));
        tv.push_back(mk(0,1,0,2'b11, 'h240,'h1240,1, 'h250,'h1250,0, 2'b00, 0,'h200,'h1200,1,0));
        tv.push_back(mk(0,0,0,2'b10, 0,0,0, 'h300,'h1300,1, 2'b10, 1,'h300,'h1300,1,1));
        tv.push_back(mk(0,0,0,2'b00, 0,0,0, 0,0,0, 2'b00, 0,'h300,'h1300,1,0));
        tv.push_back(mk(0,0,1,2'b01, 'h400,'h1400,1, 0,0,0, 2'b01, 0,'h300,'h1300,1,1));
        tv.push_back(mk(0,0,1,2'b10, 0,0,0, 'h410,'h1410,0, 2'b10, 0,'h300,'h1300,1,1));
        tv.push_back(mk(0,0,0,2'b01, 'h420,'h1420,1, 0,0,0, 2'b01, 1,'h400,'h1400,1,1));
        tv.push_back(mk(1,0,0,2'b11, 'h430,'h1430,1, 'h440,'h1440,0, 2'b00, 0,0,0,0,0));
        tv.push_back(mk(0,0,0,2'b00, 0,0,0, 0,0,0, 2'b00, 0,0,0,0,0));
        tv.push_back(mk(0,0,0,2'b00, 0,0,0, 0,0,0, 2'b00, 0,0,0,0,0));

        for (int n = 0; n < tv.size(); n++) begin
            drive(tv[n].rst, tv[n].fl, tv[n].hd, tv[n].v,
                  tv[n].p0, tv[n].t0, tv[n].k0,
                  tv[n].p1, tv[n].t1, tv[n].k1);
            #1;
            chk($sformatf("vec%0d req_ready", n),
                {30'b0, bus.req_ready}, {30'b0, tv[n].rdy});
            @(posedge CLK);
            #1;
            chk_out($sformatf("vec%0d", n), tv[n].upd, tv[n].opc,
                    tv[n].otg, tv[n].otk, tv[n].bsy);
        end

        // Model state matches the quiescent post-reset DUT here.
        mq.delete();
        mout = '{pc: 0, tgt: 0, tk: 0};
        mupd = 1'b0;
        mptr = 0;
        mst  = 0;
        pcl[0] = 32'h40; pcl[1] = 32'h44; pcl[2] = 32'h48;

        for (int c = 0; c < 600; c++) begin
            r_rst = ($urandom_range(0, 99) == 0);
            r_fl  = ($urandom_range(0, 39) == 0);
            r_hd  = ($urandom_range(0, 2) == 0);
            rv    = 2'($urandom_range(0, 3));
            p0 = pcl[$urandom_range(0, 2)];
            p1 = pcl[$urandom_range(0, 2)];
            t0 = $urandom; t1 = $urandom;
            k0 = 1'($urandom_range(0, 1));
            k1 = 1'($urandom_range(0, 1));
            drive(r_rst, r_fl, r_hd, rv, p0, t0, k0, p1, t1, k1);

            g = -1;
            exp_rdy = 2'b00;
            if (!r_rst && !r_fl && mq.size() < DEPTH) begin
                for (int k = 0; k < NREQ; k++) begin
                    i = (mptr + k) % NREQ;
                    if (g < 0 && rv[i]) g = i;
                end
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            #1;
            chk($sformatf("rnd%0d req_ready", c),
                {30'b0, bus.req_ready}, {30'b0, exp_rdy});

            if (r_rst) begin
                mq.delete();
                mout = '{pc: 0, tgt: 0, tk: 0};
                mupd = 1'b0; mptr = 0; mst = 0;
            end else if (r_fl) begin
                mq.delete();
                mupd = 1'b0; mst = 0;
            end else begin
                pre = mq.size();
                if (g >= 0) begin
                    e = (g == 0) ? '{pc: p0, tgt: t0, tk: k0}
                                 : '{pc: p1, tgt: t1, tk: k1};
                    mptr = (g + 1) % NREQ;
                    if (pre >= 2 && mq[$].pc == e.pc) mq[$] = e;
                    else mq.push_back(e);
                end
                mupd = 1'b0;
                if (!r_hd && mq.size() > 0) begin
                    mout = mq.pop_front();
                    mupd = 1'b1;
                end
                if (mst == 0) begin
                    if (g >= 0) mst = 1;
                end else if (mst == 1) begin
                    if (r_hd) mst = 2;
                    else if (mq.size() == 0 && g < 0) mst = 0;
                end else begin
                    if (!r_hd) mst = (pre > 0) ? 1 : 0;
                end
            end

            @(posedge CLK);
            #1;
            chk_out($sformatf("rnd%0d", c), mupd, mout.pc, mout.tgt,
                    mout.tk, (mst != 0) || mupd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
